// File: rtl/booth_r8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r8_pkg
//  Purpose  : Shared types and constants for the radix-8 Booth controller.
//  Revision : 1.0  initial release
// ============================================================================
package booth_r8_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRE   = 3'd2,
        S_EVAL  = 3'd3,
        S_ADD   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] SEL_1X = 2'b00;
    localparam logic [1:0] SEL_2X = 2'b01;
    localparam logic [1:0] SEL_3X = 2'b10;
    localparam logic [1:0] SEL_4X = 2'b11;

    // Radix-8 iterations needed to cover the sign-extended width+1 multiplier.
    function automatic int iter_of(input int width);
        return (width + 3) / 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r8_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r8_ctrl_if
//  Purpose  : Controller <-> datapath strobe bundle for the radix-8 Booth unit.
//  Revision : 1.0  initial release
// ============================================================================
interface booth_r8_ctrl_if;
    logic       start;
    logic [3:0] window;
    logic       load;
    logic       pre3;
    logic       add;
    logic       addc;
    logic [1:0] sel;
    logic       shift;
    logic       busy;
    logic       done;

    modport slave (
        input  start, window,
        output load, pre3, add, addc, sel, shift, busy, done
    );

    modport master (
        output start, window,
        input  load, pre3, add, addc, sel, shift, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/booth_r8_digit_dec.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r8_digit_dec
//  Purpose  : 4-bit Booth window -> {nonzero, negative, multiple select}.
//  Revision : 1.0  initial release
// ============================================================================
module booth_r8_digit_dec (
    input  wire logic [3:0] i_window,
    output logic            o_nz,
    output logic            o_neg,
    output logic [1:0]      o_sel
);
    logic [2:0] w_sum;
    logic [2:0] w_mag;

    // d = -4*w3 + w_sum, so |d| is w_sum or 4-w_sum depending on the sign bit.
    assign w_sum = {1'b0, i_window[2], 1'b0} + {2'b00, i_window[1]} + {2'b00, i_window[0]};
    assign w_mag = i_window[3] ? (3'd4 - w_sum) : w_sum;
    assign o_nz  = |w_mag;
    assign o_neg = i_window[3] & o_nz;
    assign o_sel = w_mag[1:0] - 2'd1;
endmodule
`default_nettype wire

// File: rtl/booth_r8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r8_ctrl
//  Purpose  : Radix-8 Booth sequencing controller (Load/Pre3/Add/Addc/Shift).
//  Revision : 1.0  initial release
// ============================================================================
module booth_r8_ctrl
    import booth_r8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    booth_r8_ctrl_if.slave  bus
);
    localparam int ITER = iter_of(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [1:0]         r_sel;
    logic               w_nz;
    logic               w_neg;
    logic [1:0]         w_sel;
    logic               w_last;
    logic               w_load;
    logic               w_pre3;
    logic               w_add;
    logic               w_addc;
    logic               w_shift;
    logic               w_done;

    booth_r8_digit_dec u_dec (
        .i_window (bus.window),
        .o_nz     (w_nz),
        .o_neg    (w_neg),
        .o_sel    (w_sel)
    );

    assign w_last = (r_cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_sel   <= SEL_1X;
        end else begin
            r_state <= w_next;
            // Digit is latched only when nonzero so Sel holds across skipped adds.
            if (r_state == S_EVAL && w_nz) begin
                r_neg <= w_neg;
                r_sel <= w_sel;
            end
            if (r_state == S_SHIFT) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_pre3  = 1'b0;
        w_add   = 1'b0;
        w_addc  = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LOAD;
            S_LOAD:  begin w_load = 1'b1; w_next = S_PRE;  end
            S_PRE:   begin w_pre3 = 1'b1; w_next = S_EVAL; end
            S_EVAL:  w_next = w_nz ? S_ADD : S_SHIFT;
            S_ADD:   begin
                w_add  = ~r_neg;
                w_addc = r_neg;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                w_next  = w_last ? S_DONE : S_EVAL;
            end
            S_DONE:  begin w_done = 1'b1; w_next = S_IDLE; end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.load  = w_load;
    assign bus.pre3  = w_pre3;
    assign bus.add   = w_add;
    assign bus.addc  = w_addc;
    assign bus.sel   = r_sel;
    assign bus.shift = w_shift;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = w_done;
endmodule
`default_nettype wire

// File: tb/tb_booth_r8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_r8_ctrl
//  Purpose  : Self-checking bench for booth_r8_ctrl with a datapath model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_r8_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  op_m = 8'h00;
    logic signed [15:0] dp = '0;

    always #5 clk = ~clk;

    booth_r8_ctrl_if bus ();

    booth_r8_ctrl #(.WIDTH(8), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] dec_w;
    logic       dec_nz;
    logic       dec_neg;
    logic [1:0] dec_sel;

    booth_r8_digit_dec u_dec (
        .i_window (dec_w),
        .o_nz     (dec_nz),
        .o_neg    (dec_neg),
        .o_sel    (dec_sel)
    );

    // Datapath multiplier register: {sign-extended Mplier, 0}, arithmetic >>3 per Shift.
    always @(posedge clk) begin
        if (bus.load)       dp <= {{7{op_m[7]}}, op_m, 1'b0};
        else if (bus.shift) dp <= dp >>> 3;
    end
    assign bus.window = dp[3:0];

    function automatic int bit_of(input logic [7:0] m, input int j);
        if (j < 0) return 0;
        if (j > 7) return int'(m[7]);
        return int'(m[j]);
    endfunction

    function automatic int digit(input logic [7:0] m, input int i);
        return -4 * bit_of(m, 3*i+2) + 2 * bit_of(m, 3*i+1) + bit_of(m, 3*i) + bit_of(m, 3*i-1);
    endfunction

    // {load, pre3, add, addc, shift, busy, done}
    function automatic logic [6:0] obs();
        return {bus.load, bus.pre3, bus.add, bus.addc, bus.shift, bus.busy, bus.done};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] m, input bit keep, input bit noise);
        logic [6:0] eq[$];
        logic [1:0] sq[$];
        int d;
        eq.push_back(7'b1000010); sq.push_back(2'b00);
        eq.push_back(7'b0100010); sq.push_back(2'b00);
        for (int i = 0; i < 3; i++) begin
            d = digit(m, i);
            eq.push_back(7'b0000010); sq.push_back(2'b00);
            if (d != 0) begin
                eq.push_back(d > 0 ? 7'b0010010 : 7'b0001010);
                sq.push_back(2'((d > 0 ? d : -d) - 1));
            end
            eq.push_back(7'b0000110); sq.push_back(2'b00);
        end
        eq.push_back(7'b0000011); sq.push_back(2'b00);

        op_m      = m;
        bus.start = 1'b1;
        cyc();
        for (int c = 0; c < eq.size(); c++) begin
            if (!keep) bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            checks++;
            if (obs() !== eq[c] || ((eq[c][4] | eq[c][3]) && bus.sel !== sq[c])) begin
                errors++;
                $display("FAIL op %02h cycle %0d: got strobes=%b sel=%b, expected strobes=%b sel=%b",
                         m, c + 1, obs(), bus.sel, eq[c], sq[c]);
            end
            cyc();
        end
        if (!keep) bus.start = 1'b0;
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL op %02h idle-after-done: got strobes=%b, expected 0000000", m, obs());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        repeat (3) cyc();
        checks++;
        if (obs() !== 7'b0 || bus.sel !== 2'b00) begin
            errors++;
            $display("FAIL reset: got strobes=%b sel=%b, expected 0000000 sel=00", obs(), bus.sel);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        cyc();
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got strobes=%b, expected 0000000", obs());
        end
    endtask

    task automatic test_directed();
        run_op(8'h00, 1'b0, 1'b0);
        run_op(8'h07, 1'b0, 1'b0);
        run_op(8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(8'h04, 1'b1, 1'b0);
        run_op(8'h03, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        bit bad;
        op_m      = 8'h07;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (3) cyc();
        checks++;
        if (obs() !== 7'b0001010 || bus.sel !== 2'b00) begin
            errors++;
            $display("FAIL abort_in_add: got strobes=%b sel=%b, expected 0001010 sel=00", obs(), bus.sel);
        end
        rst_n = 1'b0;
        cyc();
        checks++;
        if (obs() !== 7'b0 || bus.sel !== 2'b00) begin
            errors++;
            $display("FAIL abort_reset: got strobes=%b sel=%b, expected 0000000 sel=00", obs(), bus.sel);
        end
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_no_resume: got busy/done activity=1, expected 0");
        end
        run_op(8'h07, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_op(8'($urandom), 1'b0, 1'b1);
        end
    endtask

    task automatic test_decoder();
        int  d;
        bit  enz;
        bit  eneg;
        logic [1:0] esel;
        for (int w = 0; w < 16; w++) begin
            dec_w = 4'(w);
            #1;
            d    = -4 * ((w >> 3) & 1) + 2 * ((w >> 2) & 1) + ((w >> 1) & 1) + (w & 1);
            enz  = (d != 0);
            eneg = (d < 0);
            esel = enz ? 2'((d < 0 ? -d : d) - 1) : 2'b00;
            checks++;
            if (dec_nz !== enz || dec_neg !== eneg || (enz && dec_sel !== esel)) begin
                errors++;
                $display("FAIL decoder w=%b: got nz=%b neg=%b sel=%b, expected nz=%b neg=%b sel=%b",
                         4'(w), dec_nz, dec_neg, dec_sel, enz, eneg, esel);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        rst_n     = 1'b0;
        dec_w     = 4'b0000;
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        test_decoder();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
